// File: rtl/ysyx_22050710_exe_stage_pkg.sv
// Shared widths, bus layouts, ALU op bits and request-FSM codes for the execute stage.
package ysyx_22050710_exe_stage_pkg;

    localparam int WORD_WD      = 64;
    localparam int GPR_ADDR_WD  = 5;
    localparam int CSR_ADDR_WD  = 12;
    localparam int ALU_OP_WD    = 16;
    localparam int SRAM_DATA_WD = 64;
    localparam int STRB_WD      = SRAM_DATA_WD / 8;

    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_SLT  = 2;
    localparam int OP_SLTU = 3;
    localparam int OP_AND  = 4;
    localparam int OP_OR   = 5;
    localparam int OP_XOR  = 6;
    localparam int OP_SLL  = 7;
    localparam int OP_SRL  = 8;
    localparam int OP_SRA  = 9;
    localparam int OP_LUI  = 10;
    localparam int OP_ADDW = 11;
    localparam int OP_SUBW = 12;
    localparam int OP_SLLW = 13;
    localparam int OP_SRLW = 14;
    localparam int OP_SRAW = 15;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_D = 2'b11;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_ADDR = 2'd1;
    localparam logic [1:0] ST_SENT      = 2'd2;

    typedef struct packed {
        logic [ALU_OP_WD-1:0]   alu_op;
        logic [WORD_WD-1:0]     src1;
        logic [WORD_WD-1:0]     src2;
        logic [WORD_WD-1:0]     rs2_data;
        logic [GPR_ADDR_WD-1:0] rd;
        logic [CSR_ADDR_WD-1:0] csr;
        logic                   gpr_wen;
        logic                   csr_wen;
        logic                   mem_ren;
        logic                   mem_wen;
        logic [2:0]             mem_op;
        logic                   csr_inst_sel;
        logic [WORD_WD-1:0]     csrrdata;
        logic [WORD_WD-1:0]     csr_result;
    } ds_to_es_t;

    typedef struct packed {
        logic [GPR_ADDR_WD-1:0] rd;
        logic [CSR_ADDR_WD-1:0] csr;
        logic                   gpr_wen;
        logic                   csr_wen;
        logic                   mem_ren;
        logic                   mem_wen;
        logic [2:0]             mem_op;
        logic                   csr_inst_sel;
        logic [WORD_WD-1:0]     csrrdata;
        logic [WORD_WD-1:0]     alu_result;
        logic [WORD_WD-1:0]     csr_result;
    } es_to_ms_t;

    typedef struct packed {
        logic [GPR_ADDR_WD-1:0] rd;
        logic [WORD_WD-1:0]     gpr_result;
        logic [CSR_ADDR_WD-1:0] csr;
        logic [WORD_WD-1:0]     csr_result;
    } bypass_t;

    localparam int DS_TO_ES_BUS_WD = $bits(ds_to_es_t);
    localparam int ES_TO_MS_BUS_WD = $bits(es_to_ms_t);
    localparam int BYPASS_BUS_WD   = $bits(bypass_t);

    function automatic logic [STRB_WD-1:0] size_mask(input logic [1:0] size);
        case (size)
            SIZE_B:  return 8'h01;
            SIZE_H:  return 8'h03;
            SIZE_W:  return 8'h0f;
            default: return 8'hff;
        endcase
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_bits(input logic [1:0] size);
        case (size)
            SIZE_B:  return 3'b000;
            SIZE_H:  return 3'b001;
            SIZE_W:  return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    function automatic logic [WORD_WD-1:0] sext32(input logic [31:0] v);
        return {{(WORD_WD-32){v[31]}}, v};
    endfunction

endpackage

// File: rtl/ysyx_22050710_exe_stage_alu.sv
// Combinational ALU: one-hot op select, 64-bit ops plus 32-bit W variants sign-extended.
module ysyx_22050710_exe_stage_alu
    import ysyx_22050710_exe_stage_pkg::*;
(
    input  logic [ALU_OP_WD-1:0] alu_op,
    input  logic [WORD_WD-1:0]   src1,
    input  logic [WORD_WD-1:0]   src2,
    output logic [WORD_WD-1:0]   result
);
    logic [WORD_WD-1:0] sum, diff, sll, srl, sra;
    logic [31:0]        sum_w, diff_w, sll_w, srl_w, sra_w;
    logic               slt, sltu;
    logic [5:0]         shamt;
    logic [4:0]         shamt_w;

    assign shamt   = src2[5:0];
    assign shamt_w = src2[4:0];
    assign sum     = src1 + src2;
    assign diff    = src1 - src2;
    assign slt     = $signed(src1) < $signed(src2);
    assign sltu    = src1 < src2;
    assign sll     = src1 << shamt;
    assign srl     = src1 >> shamt;
    assign sra     = $signed(src1) >>> shamt;
    assign sum_w   = src1[31:0] + src2[31:0];
    assign diff_w  = src1[31:0] - src2[31:0];
    assign sll_w   = src1[31:0] << shamt_w;
    assign srl_w   = src1[31:0] >> shamt_w;
    assign sra_w   = $signed(src1[31:0]) >>> shamt_w;

    always_comb begin
        result = '0;
        if (alu_op[OP_ADD])  result = result | sum;
        if (alu_op[OP_SUB])  result = result | diff;
        if (alu_op[OP_SLT])  result = result | {{(WORD_WD-1){1'b0}}, slt};
        if (alu_op[OP_SLTU]) result = result | {{(WORD_WD-1){1'b0}}, sltu};
        if (alu_op[OP_AND])  result = result | (src1 & src2);
        if (alu_op[OP_OR])   result = result | (src1 | src2);
        if (alu_op[OP_XOR])  result = result | (src1 ^ src2);
        if (alu_op[OP_SLL])  result = result | sll;
        if (alu_op[OP_SRL])  result = result | srl;
        if (alu_op[OP_SRA])  result = result | sra;
        if (alu_op[OP_LUI])  result = result | src2;
        if (alu_op[OP_ADDW]) result = result | sext32(sum_w);
        if (alu_op[OP_SUBW]) result = result | sext32(diff_w);
        if (alu_op[OP_SLLW]) result = result | sext32(sll_w);
        if (alu_op[OP_SRLW]) result = result | sext32(srl_w);
        if (alu_op[OP_SRAW]) result = result | sext32(sra_w);
    end

endmodule

// File: rtl/ysyx_22050710_exe_stage.sv
// Execute stage: registers the decode bus, runs the ALU, issues data-sram requests
// and drives the es->ms and bypass buses.
module ysyx_22050710_exe_stage
    import ysyx_22050710_exe_stage_pkg::*;
#(
    parameter int DEBUG_BUS_WD = 64
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_ms_allowin,
    output logic                       o_es_allowin,
    input  logic                       i_ds_to_es_valid,
    input  logic [DS_TO_ES_BUS_WD-1:0] i_ds_to_es_bus,
    output logic                       o_es_to_ms_valid,
    output logic [ES_TO_MS_BUS_WD-1:0] o_es_to_ms_bus,
    output logic                       o_data_sram_req,
    output logic                       o_data_sram_wr,
    output logic [1:0]                 o_data_sram_size,
    output logic [WORD_WD-1:0]         o_data_sram_addr,
    output logic [STRB_WD-1:0]         o_data_sram_wstrb,
    output logic [SRAM_DATA_WD-1:0]    o_data_sram_wdata,
    input  logic                       i_data_sram_addr_ok,
    output logic [BYPASS_BUS_WD-1:0]   o_es_to_ds_bypass_bus,
    output logic                       o_es_load_pending,
    input  logic [DEBUG_BUS_WD-1:0]    i_debug_ds_to_es_bus,
    output logic [DEBUG_BUS_WD-1:0]    o_debug_es_to_ms_bus
);
    ds_to_es_t                es_r;
    es_to_ms_t                ms_bus;
    bypass_t                  bypass;
    logic [DEBUG_BUS_WD-1:0]  debug_r;
    logic [1:0]               state, state_nxt;
    logic                     es_valid, es_ready_go, mem;
    logic [WORD_WD-1:0]       alu_result;

    assign mem              = es_r.mem_ren | es_r.mem_wen;
    assign o_es_allowin     = !es_valid || (es_ready_go && i_ms_allowin);
    assign o_es_to_ms_valid = es_valid && es_ready_go;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)            es_valid <= 1'b0;
        else if (o_es_allowin) es_valid <= i_ds_to_es_valid;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            es_r    <= '0;
            debug_r <= '0;
        end else if (i_ds_to_es_valid && o_es_allowin) begin
            es_r    <= i_ds_to_es_bus;
            debug_r <= i_debug_ds_to_es_bus;
        end
    end

    ysyx_22050710_exe_stage_alu u_alu (
        .alu_op (es_r.alu_op),
        .src1   (es_r.src1),
        .src2   (es_r.src2),
        .result (alu_result)
    );

    // First assertion waits for ms to have room, so ms never sees two requests in flight.
    always_comb begin
        state_nxt       = state;
        es_ready_go     = 1'b1;
        o_data_sram_req = 1'b0;
        if (es_valid && mem) begin
            case (state)
                ST_IDLE: begin
                    o_data_sram_req = i_ms_allowin;
                    es_ready_go     = i_ms_allowin && i_data_sram_addr_ok;
                    if (i_ms_allowin && !i_data_sram_addr_ok) state_nxt = ST_WAIT_ADDR;
                end
                ST_WAIT_ADDR: begin
                    o_data_sram_req = 1'b1;
                    es_ready_go     = i_data_sram_addr_ok;
                    if (i_data_sram_addr_ok) state_nxt = i_ms_allowin ? ST_IDLE : ST_SENT;
                end
                ST_SENT: begin
                    if (i_ms_allowin) state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    assign o_data_sram_wr   = es_r.mem_wen;
    assign o_data_sram_size = es_r.mem_op[1:0];
    assign o_data_sram_addr = alu_result;

    always_comb begin
        o_data_sram_wstrb = es_r.mem_wen ? (size_mask(o_data_sram_size) << o_data_sram_addr[2:0]) : '0;
        case (o_data_sram_size)
            SIZE_B:  o_data_sram_wdata = {8{es_r.rs2_data[7:0]}};
            SIZE_H:  o_data_sram_wdata = {4{es_r.rs2_data[15:0]}};
            SIZE_W:  o_data_sram_wdata = {2{es_r.rs2_data[31:0]}};
            default: o_data_sram_wdata = es_r.rs2_data;
        endcase
    end

    a_aligned: assert property (@(posedge i_clk) disable iff (!i_rst)
        o_data_sram_req |-> ((o_data_sram_addr[2:0] & align_bits(o_data_sram_size)) == 3'b000));

    always_comb begin
        ms_bus.rd           = es_r.rd;
        ms_bus.csr          = es_r.csr;
        ms_bus.gpr_wen      = es_r.gpr_wen;
        ms_bus.csr_wen      = es_r.csr_wen;
        ms_bus.mem_ren      = es_r.mem_ren;
        ms_bus.mem_wen      = es_r.mem_wen;
        ms_bus.mem_op       = es_r.mem_op;
        ms_bus.csr_inst_sel = es_r.csr_inst_sel;
        ms_bus.csrrdata     = es_r.csrrdata;
        ms_bus.alu_result   = alu_result;
        ms_bus.csr_result   = es_r.csr_result;
    end

    assign o_es_to_ms_bus       = ms_bus;
    assign o_debug_es_to_ms_bus = debug_r;

    // Loads forward their address here; decode must use load_pending to stall instead.
    always_comb begin
        bypass = '0;
        if (es_valid && !es_r.mem_wen) begin
            if (es_r.gpr_wen) begin
                bypass.rd         = es_r.rd;
                bypass.gpr_result = es_r.csr_inst_sel ? es_r.csrrdata : alu_result;
            end
            if (es_r.csr_wen) begin
                bypass.csr        = es_r.csr;
                bypass.csr_result = es_r.csr_result;
            end
        end
    end

    assign o_es_to_ds_bypass_bus = bypass;
    assign o_es_load_pending     = es_valid && es_r.mem_ren;

endmodule

// File: tb/tb_ysyx_22050710_exe_stage.sv
// Bench for the execute stage: directed protocol scenarios plus random traffic
// checked against a transaction-level model of one instruction in flight.
module tb_ysyx_22050710_exe_stage;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         ms_allowin = 1'b0, ds_valid = 1'b0, addr_ok = 1'b0;
    logic [360:0] ds_bus = '0;
    logic [63:0]  dbg_in = '0;
    logic         es_allowin, es_to_ms_valid, req, wr, load_pending;
    logic [216:0] es_bus;
    logic [1:0]   size;
    logic [63:0]  addr, wdata, dbg_out;
    logic [7:0]   wstrb;
    logic [144:0] bypass;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          k;
        logic [15:0] op;
        logic [63:0] s1, s2, rs2, crd, cres, dbg;
        logic [4:0]  rd;
        logic [11:0] csr;
        logic        gw, cw, mr, mw, sel;
        logic [2:0]  mop;
    } ins_t;

    ins_t drv, cur;
    bit   occ = 0, acc = 0, pend = 0;

    always #5 clk = ~clk;

    ysyx_22050710_exe_stage dut (
        .i_clk                 (clk),
        .i_rst                 (rst),
        .i_ms_allowin          (ms_allowin),
        .o_es_allowin          (es_allowin),
        .i_ds_to_es_valid      (ds_valid),
        .i_ds_to_es_bus        (ds_bus),
        .o_es_to_ms_valid      (es_to_ms_valid),
        .o_es_to_ms_bus        (es_bus),
        .o_data_sram_req       (req),
        .o_data_sram_wr        (wr),
        .o_data_sram_size      (size),
        .o_data_sram_addr      (addr),
        .o_data_sram_wstrb     (wstrb),
        .o_data_sram_wdata     (wdata),
        .i_data_sram_addr_ok   (addr_ok),
        .o_es_to_ds_bypass_bus (bypass),
        .o_es_load_pending     (load_pending),
        .i_debug_ds_to_es_bus  (dbg_in),
        .o_debug_es_to_ms_bus  (dbg_out)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [360:0] pack_ds(input ins_t i);
        return {i.op, i.s1, i.s2, i.rs2, i.rd, i.csr, i.gw, i.cw, i.mr, i.mw, i.mop, i.sel, i.crd, i.cres};
    endfunction

    function automatic logic [63:0] alu_ref(input ins_t i);
        logic [63:0] a, b;
        logic [31:0] r;
        a = i.s1;
        b = i.s2;
        r = '0;
        case (i.k)
            0:  return a + b;
            1:  return a - b;
            2:  return (longint'(a) < longint'(b)) ? 64'd1 : 64'd0;
            3:  return (a < b) ? 64'd1 : 64'd0;
            4:  return a & b;
            5:  return a | b;
            6:  return a ^ b;
            7:  return a << b[5:0];
            8:  return a >> b[5:0];
            9:  return 64'(longint'(a) >>> b[5:0]);
            10: return b;
            11: r = a[31:0] + b[31:0];
            12: r = a[31:0] - b[31:0];
            13: r = a[31:0] << b[4:0];
            14: r = a[31:0] >> b[4:0];
            default: r = 32'(int'(a[31:0]) >>> b[4:0]);
        endcase
        return 64'(longint'(int'(r)));
    endfunction

    function automatic logic [216:0] exp_bus(input ins_t i);
        return {i.rd, i.csr, i.gw, i.cw, i.mr, i.mw, i.mop, i.sel, i.crd, alu_ref(i), i.cres};
    endfunction

    function automatic logic [144:0] exp_byp(input ins_t i);
        logic [4:0]  r = '0;
        logic [63:0] g = '0, cr = '0;
        logic [11:0] c = '0;
        if (!i.mw) begin
            if (i.gw) begin r = i.rd; g = i.sel ? i.crd : alu_ref(i); end
            if (i.cw) begin c = i.csr; cr = i.cres; end
        end
        return {r, g, c, cr};
    endfunction

    function automatic logic [7:0] exp_strb(input ins_t i);
        int n = 1 << i.mop[1:0];
        logic [63:0] a = alu_ref(i);
        if (!i.mw) return 8'h00;
        return 8'(((1 << n) - 1) << a[2:0]);
    endfunction

    function automatic logic [63:0] exp_wdata(input ins_t i);
        int n = 1 << i.mop[1:0];
        logic [63:0] d;
        for (int b = 0; b < 8; b++) d[8*b +: 8] = i.rs2[8*(b % n) +: 8];
        return d;
    endfunction

    // kind: 0 ALU op, 1 load, 2 store (addresses kept naturally aligned)
    function automatic ins_t rnd(input int kind);
        ins_t i;
        int n;
        i.k = (kind == 0) ? int'($urandom_range(15, 0)) : 0;
        i.op = 16'(1) << i.k;
        i.s1 = {$urandom, $urandom};
        i.s2 = {$urandom, $urandom};
        if ($urandom_range(1, 0) == 1) i.s2 = 64'($urandom_range(70, 0));
        i.rs2 = {$urandom, $urandom};
        i.crd = {$urandom, $urandom};
        i.cres = {$urandom, $urandom};
        i.dbg = {$urandom, $urandom};
        i.rd = 5'($urandom);
        i.csr = 12'($urandom);
        i.gw = 1'($urandom);
        i.cw = 1'($urandom);
        i.sel = 1'($urandom);
        i.mop = 3'($urandom);
        i.mr = 1'b0;
        i.mw = 1'b0;
        if (kind != 0) begin
            n = 1 << i.mop[1:0];
            i.s1 = {$urandom, $urandom} & ~64'h7;
            i.s2 = 64'(n * int'($urandom_range(3, 0)));
            i.mr = (kind == 1);
            i.mw = (kind == 2);
            if (kind == 1) i.gw = 1'b1;
        end
        return i;
    endfunction

    task automatic set_in(input logic v, input ins_t i, input logic ma, input logic ao);
        ds_valid = v;
        drv = i;
        ds_bus = pack_ds(i);
        dbg_in = i.dbg;
        ms_allowin = ma;
        addr_ok = ao;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: at most one instruction in es; acc = its request was accepted,
    // pend = its request is showing but not yet accepted.
    always @(negedge clk) begin : model
        bit mem;
        if (!rst) begin
            occ = 0; acc = 0; pend = 0;
        end else begin
            if (occ) begin
                mem = cur.mr || cur.mw;
                chk("bypass", 256'(bypass), 256'(exp_byp(cur)));
                chk("load_pending", 256'(load_pending), 256'(cur.mr));
                chk("debug", 256'(dbg_out), 256'(cur.dbg));
                chk("req", 256'(req), 256'(mem && !acc && (pend || ms_allowin)));
                if (req) begin
                    chk("addr", 256'(addr), 256'(alu_ref(cur)));
                    chk("wr", 256'(wr), 256'(cur.mw));
                    chk("size", 256'(size), 256'(cur.mop[1:0]));
                    chk("wstrb", 256'(wstrb), 256'(exp_strb(cur)));
                    if (cur.mw) chk("wdata", 256'(wdata), 256'(exp_wdata(cur)));
                    if (addr_ok) acc = 1;
                    else pend = 1;
                end
                chk("valid", 256'(es_to_ms_valid), 256'(!mem || acc));
                chk("allowin", 256'(es_allowin), 256'((!mem || acc) && ms_allowin));
                if (es_to_ms_valid) chk("es_bus", 256'(es_bus), 256'(exp_bus(cur)));
                if (es_to_ms_valid && ms_allowin) begin
                    occ = 0; acc = 0; pend = 0;
                end
            end else begin
                chk("idle_valid", 256'(es_to_ms_valid), 256'(0));
                chk("idle_req", 256'(req), 256'(0));
                chk("idle_bypass", 256'(bypass), 256'(0));
                chk("idle_load_pending", 256'(load_pending), 256'(0));
                chk("idle_allowin", 256'(es_allowin), 256'(1));
            end
            if (ds_valid && es_allowin) begin
                occ = 1; cur = drv; acc = 0; pend = 0;
            end
        end
    end

    initial begin
        ins_t a, sd, sb, lw, st, ld2;
        #2;
        chk("rst_valid", 256'(es_to_ms_valid), 256'(0));
        chk("rst_req", 256'(req), 256'(0));
        chk("rst_bypass", 256'(bypass), 256'(0));
        chk("rst_es_bus", 256'(es_bus), 256'(0));
        chk("rst_allowin", 256'(es_allowin), 256'(1));
        @(posedge clk);
        #1 rst = 1'b1;

        // add x1 = 3 + 4
        a = rnd(0);
        a.k = 0; a.op = 16'h0001; a.s1 = 64'd3; a.s2 = 64'd4;
        a.rd = 5'd1; a.gw = 1'b1; a.cw = 1'b0; a.sel = 1'b0;
        set_in(1, a, 1, 0); tick();
        set_in(0, a, 1, 0); #1;
        chk("add_valid", 256'(es_to_ms_valid), 256'(1));
        chk("add_alu", 256'(es_bus[127:64]), 256'(7));
        chk("add_bypass", 256'(bypass), 256'({5'd1, 64'd7, 12'd0, 64'd0}));
        chk("add_req", 256'(req), 256'(0));
        tick();

        // sd with same-cycle addr_ok
        sd = rnd(2);
        sd.mop = 3'b011; sd.s1 = 64'h8000_0008; sd.s2 = 64'd0; sd.rs2 = 64'h1122_3344_5566_7788;
        set_in(1, sd, 1, 1); tick();
        set_in(0, sd, 1, 1); #1;
        chk("sd_req", 256'(req), 256'(1));
        chk("sd_size", 256'(size), 256'(3));
        chk("sd_wstrb", 256'(wstrb), 256'(8'hff));
        chk("sd_wdata", 256'(wdata), 256'(64'h1122_3344_5566_7788));
        chk("sd_valid", 256'(es_to_ms_valid), 256'(1));
        tick();
        set_in(0, sd, 1, 1); #1;
        chk("sd_req_once", 256'(req), 256'(0));
        tick();

        // sb with addr_ok after 3 cycles, ms_allowin dropping while waiting
        sb = rnd(2);
        sb.mop = 3'b000; sb.s1 = 64'h8000_0000; sb.s2 = 64'd3; sb.rs2 = 64'h0000_0000_0000_00ab;
        set_in(1, sb, 1, 0); tick();
        for (int c = 0; c < 3; c++) begin
            set_in(0, sb, (c == 0), 0); #1;
            chk("sb_req_held", 256'(req), 256'(1));
            chk("sb_wstrb", 256'(wstrb), 256'(8'h08));
            chk("sb_wdata", 256'(wdata), 256'(64'habab_abab_abab_abab));
            tick();
        end
        set_in(0, sb, 1, 1); tick();
        set_in(0, sb, 1, 1); #1;
        chk("sb_no_reissue", 256'(req), 256'(0));
        tick();

        // lw while ms is stalled for 2 cycles
        lw = rnd(1);
        lw.mop = 3'b010; lw.s1 = 64'h8000_0100; lw.s2 = 64'd4;
        set_in(1, lw, 0, 1); tick();
        for (int c = 0; c < 2; c++) begin
            set_in(0, lw, 0, 1); #1;
            chk("lw_req_gated", 256'(req), 256'(0));
            chk("lw_pending", 256'(load_pending), 256'(1));
            tick();
        end
        set_in(0, lw, 1, 1); #1;
        chk("lw_req", 256'(req), 256'(1));
        chk("lw_pending_go", 256'(load_pending), 256'(1));
        tick();

        // addr_ok arrives while ms is full: request done, valid held until ms frees
        st = rnd(2);
        st.mop = 3'b010; st.s1 = 64'h8000_0200; st.s2 = 64'd8;
        set_in(1, st, 1, 0); tick();
        set_in(0, st, 1, 0); tick();
        set_in(0, st, 0, 1); #1;
        chk("sent_req_ok", 256'(req), 256'(1));
        tick();
        for (int c = 0; c < 2; c++) begin
            set_in(0, st, 0, 1); #1;
            chk("sent_req_low", 256'(req), 256'(0));
            chk("sent_valid", 256'(es_to_ms_valid), 256'(1));
            tick();
        end
        set_in(0, st, 1, 0); tick();

        // async reset during an outstanding load request
        ld2 = rnd(1);
        ld2.mop = 3'b011; ld2.s1 = 64'h8000_0300; ld2.s2 = 64'd8;
        set_in(1, ld2, 1, 0); tick();
        set_in(0, ld2, 1, 0); tick();
        set_in(0, ld2, 0, 0); #1;
        chk("pre_rst_req", 256'(req), 256'(1));
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_req", 256'(req), 256'(0));
        chk("mid_rst_valid", 256'(es_to_ms_valid), 256'(0));
        chk("mid_rst_bypass", 256'(bypass), 256'(0));
        chk("mid_rst_pending", 256'(load_pending), 256'(0));
        tick(); tick();
        rst = 1'b1;
        set_in(1, a, 1, 0); tick();
        set_in(0, a, 1, 0); #1;
        chk("post_rst_alu", 256'(es_bus[127:64]), 256'(7));
        chk("post_rst_valid", 256'(es_to_ms_valid), 256'(1));
        tick();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            set_in(1'($urandom_range(1, 0)), rnd(int'($urandom_range(2, 0))),
                   ($urandom_range(3, 0) != 0), 1'($urandom_range(1, 0)));
            tick();
        end
        for (int c = 0; c < 4; c++) begin
            set_in(0, a, 1, 1);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
